// File: rtl/status_reg_stack.sv
// Processor status register with masked ALU/decoder writes and a LIFO save/restore stack.
// Optional: define STATUS_PUSH_IE_CLR_EN to clear the interrupt-enable bit on a successful push.
module status_reg_stack #(
    parameter int NumStatusBits = 6,
    parameter int StackDepth    = 4,
    parameter int IeBit         = 5
) (
    input  logic                             clk,
    input  logic                             res_n,
    input  logic                             sel_stat_in_alu_decoder,
    input  logic                             wr_en,
    input  logic [NumStatusBits-1:0]         wr_mask,
    input  logic [NumStatusBits-1:0]         alu_status,
    input  logic [NumStatusBits-1:0]         dec_status,
    input  logic                             push,
    input  logic                             pop,
    input  logic                             err_clr,
    output logic [NumStatusBits-1:0]         status,
    output logic [$clog2(StackDepth+1)-1:0]  stack_depth,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             stack_err
);

    localparam int DepthW = $clog2(StackDepth + 1);
    localparam int IdxW   = (StackDepth > 1) ? $clog2(StackDepth) : 1;

    if ((StackDepth < 1) || (IeBit < 0) || (IeBit >= NumStatusBits)) begin : g_bad_param
        $error("status_reg_stack: StackDepth must be >= 1 and IeBit inside the status width");
    end

    logic [NumStatusBits-1:0] r_stack [StackDepth];
    logic [NumStatusBits-1:0] r_status;
    logic [DepthW-1:0]        r_depth;
    logic                     r_err;

    logic [NumStatusBits-1:0] w_src;
    logic [NumStatusBits-1:0] w_wv;
    logic [NumStatusBits-1:0] w_status_nxt;
    logic [DepthW-1:0]        w_depth_nxt;
    logic                     w_err_nxt;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push_ok;
    logic                     w_pop_ok;
    logic                     w_err_set;
    logic [IdxW-1:0]          w_push_idx;
    logic [IdxW-1:0]          w_top_idx;

    // Occupancy flags and stack pointers derived from the saved-entry count
    always_comb begin
        w_full     = (r_depth == DepthW'(StackDepth));
        w_empty    = (r_depth == {DepthW{1'b0}});
        w_push_idx = IdxW'(r_depth);
        w_top_idx  = IdxW'(r_depth - DepthW'(1));
    end

    // Source selection and masked write value
    always_comb begin
        if (sel_stat_in_alu_decoder) begin
            w_src = alu_status;
        end else begin
            w_src = dec_status;
        end
        if (wr_en) begin
            w_wv = (r_status & ~wr_mask) | (w_src & wr_mask);
        end else begin
            w_wv = r_status;
        end
    end

    // Stack request arbitration: simultaneous push and pop cancel each other
    always_comb begin
        w_push_ok = 1'b0;
        w_pop_ok  = 1'b0;
        w_err_set = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (w_full) begin
                    w_err_set = 1'b1;
                end else begin
                    w_push_ok = 1'b1;
                end
            end
            2'b01: begin
                if (w_empty) begin
                    w_err_set = 1'b1;
                end else begin
                    w_pop_ok = 1'b1;
                end
            end
            default: begin
                w_push_ok = 1'b0;
                w_pop_ok  = 1'b0;
                w_err_set = 1'b0;
            end
        endcase
    end

    // Next live status, depth and sticky error; a restore discards the same-cycle write
    always_comb begin
        w_status_nxt = w_wv;
        w_depth_nxt  = r_depth;
        if (w_pop_ok) begin
            w_status_nxt = r_stack[w_top_idx];
            w_depth_nxt  = r_depth - DepthW'(1);
        end else if (w_push_ok) begin
            w_depth_nxt  = r_depth + DepthW'(1);
`ifdef STATUS_PUSH_IE_CLR_EN
            w_status_nxt[IeBit] = 1'b0;
`endif
        end else begin
            w_depth_nxt  = r_depth;
        end
        if (w_err_set) begin
            w_err_nxt = 1'b1;
        end else if (err_clr) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end
    end

    // Live status, depth and error registers
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_status <= '0;
            r_depth  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_status <= w_status_nxt;
            r_depth  <= w_depth_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Saved entries capture the pre-write status on a successful push
    always_ff @(posedge clk) begin
        if (!res_n) begin
            for (int i = 0; i < StackDepth; i++) begin
                r_stack[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_stack[w_push_idx] <= r_status;
        end else begin
            r_stack[w_push_idx] <= r_stack[w_push_idx];
        end
    end

    assign status      = r_status;
    assign stack_depth = r_depth;
    assign stack_err   = r_err;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;

endmodule

// File: tb/tb_status_reg_stack.sv
// Directed bench for status_reg_stack: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_status_reg_stack;

    localparam int NB    = 6;
    localparam int DEPTH = 4;
    localparam int IE    = 5;
    localparam int DW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          res_n;
    logic          sel;
    logic          wr_en;
    logic [NB-1:0] wr_mask;
    logic [NB-1:0] alu_status;
    logic [NB-1:0] dec_status;
    logic          push;
    logic          pop;
    logic          err_clr;
    logic [NB-1:0] status;
    logic [DW-1:0] stack_depth;
    logic          stack_full;
    logic          stack_empty;
    logic          stack_err;

    int n_pass  = 0;
    int n_total = 0;

    status_reg_stack #(.NumStatusBits(NB), .StackDepth(DEPTH), .IeBit(IE)) dut (
        .clk                     (clk),
        .res_n                   (res_n),
        .sel_stat_in_alu_decoder (sel),
        .wr_en                   (wr_en),
        .wr_mask                 (wr_mask),
        .alu_status              (alu_status),
        .dec_status              (dec_status),
        .push                    (push),
        .pop                     (pop),
        .err_clr                 (err_clr),
        .status                  (status),
        .stack_depth             (stack_depth),
        .stack_full              (stack_full),
        .stack_empty             (stack_empty),
        .stack_err               (stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: live value plus a LIFO queue of saved values
    logic [NB-1:0] m_q[$];
    logic [NB-1:0] m_status = '0;
    logic          m_err    = 1'b0;
    bit            m_valid  = 1'b0;

    always @(posedge clk) begin : model
        logic [NB-1:0] src;
        logic [NB-1:0] nxt;
        logic          e;
        if (!res_n) begin
            m_q.delete();
            m_status <= '0;
            m_err    <= 1'b0;
            m_valid  <= 1'b1;
        end else begin
            src = sel ? alu_status : dec_status;
            nxt = wr_en ? ((m_status & ~wr_mask) | (src & wr_mask)) : m_status;
            e   = 1'b0;
            if (push && !pop) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(m_status);
`ifdef STATUS_PUSH_IE_CLR_EN
                    nxt[IE] = 1'b0;
`endif
                end else begin
                    e = 1'b1;
                end
            end else if (pop && !push) begin
                if (m_q.size() > 0) begin
                    nxt = m_q.pop_back();
                end else begin
                    e = 1'b1;
                end
            end
            m_status <= nxt;
            m_err    <= e ? 1'b1 : (err_clr ? 1'b0 : m_err);
        end
    end

    // Every-cycle comparison against the model on the falling edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_status", int'(status), int'(m_status));
            chk("model_depth", int'(stack_depth), m_q.size());
            chk("model_full", int'(stack_full), int'(m_q.size() == DEPTH));
            chk("model_empty", int'(stack_empty), int'(m_q.size() == 0));
            chk("model_err", int'(stack_err), int'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
        res_n   = 1'b1;
    endtask

    task automatic wr(input logic s, input logic [NB-1:0] mask, input logic [NB-1:0] v);
        wr_en   = 1'b1;
        sel     = s;
        wr_mask = mask;
        if (s) alu_status = v;
        else   dec_status = v;
    endtask

    initial begin
        res_n = 1'b0; sel = 1'b0; wr_en = 1'b0; wr_mask = '0;
        alu_status = '0; dec_status = '0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        tick();
        chk("por_status", int'(status), 0);
        chk("por_empty", int'(stack_empty), 1);

        // Build status=3F with two saved entries, then reset with a push pending
        wr(1'b1, 6'h3F, 6'h3F); tick();
        push = 1'b1; tick();
        push = 1'b1; tick();
        chk("pre_rst_depth", int'(stack_depth), 2);
        chk("pre_rst_status", int'(status), 6'h3F);
        res_n = 1'b0; push = 1'b1; tick();
        chk("rst_status", int'(status), 0);
        chk("rst_depth", int'(stack_depth), 0);
        chk("rst_empty", int'(stack_empty), 1);
        chk("rst_full", int'(stack_full), 0);
        chk("rst_err", int'(stack_err), 0);

        // Masked writes from each source
        wr(1'b0, 6'h3F, 6'h30); tick();
        wr(1'b1, 6'h0F, 6'h2A); tick();
        chk("wr_alu", int'(status), 6'h3A);
        wr(1'b0, 6'h30, 6'h05); tick();
        chk("wr_dec", int'(status), 6'h0A);
        wr(1'b1, 6'h00, 6'h3F); tick();
        chk("wr_zero_mask", int'(status), 6'h0A);
        sel = 1'b1; wr_mask = 6'h3F; alu_status = 6'h3F; tick();
        chk("wr_disabled", int'(status), 6'h0A);

        // Push/write/push/pop/pop sequence
        wr(1'b1, 6'h3F, 6'h21); tick();
        push = 1'b1; tick();
        chk("seq1_status", int'(status), 6'h21); chk("seq1_depth", int'(stack_depth), 1);
        wr(1'b1, 6'h3F, 6'h00); tick();
        chk("seq2_status", int'(status), 6'h00); chk("seq2_depth", int'(stack_depth), 1);
        push = 1'b1; tick();
        chk("seq3_status", int'(status), 6'h00); chk("seq3_depth", int'(stack_depth), 2);
        pop = 1'b1; tick();
        chk("seq4_status", int'(status), 6'h00); chk("seq4_depth", int'(stack_depth), 1);
        pop = 1'b1; tick();
        chk("seq5_status", int'(status), 6'h21); chk("seq5_depth", int'(stack_depth), 0);

        // Fill to overflow, drain to underflow
        for (int i = 0; i < DEPTH; i++) begin
            wr(1'b1, 6'h3F, NB'(6'h10 + i)); tick();
            push = 1'b1; tick();
        end
        chk("fill_full", int'(stack_full), 1);
        chk("fill_err", int'(stack_err), 0);
        push = 1'b1; wr(1'b1, 6'h3F, 6'h14); tick();
        chk("ovf_err", int'(stack_err), 1);
        chk("ovf_depth", int'(stack_depth), 4);
        chk("ovf_write", int'(status), 6'h14);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            pop = 1'b1; tick();
            chk("drain_status", int'(status), 6'h10 + i);
            chk("drain_depth", int'(stack_depth), i);
        end
        pop = 1'b1; tick();
        chk("udf_status", int'(status), 6'h10);
        chk("udf_err", int'(stack_err), 1);
        err_clr = 1'b1; tick();
        chk("clr_err", int'(stack_err), 0);
        pop = 1'b1; err_clr = 1'b1; tick();
        chk("err_beats_clr", int'(stack_err), 1);
        err_clr = 1'b1; tick();
        chk("clr_err2", int'(stack_err), 0);

        // Push and pop together; pop against a write
        push = 1'b1; tick();
        push = 1'b1; pop = 1'b1; wr(1'b1, 6'h3F, 6'h11); tick();
        chk("pp_depth", int'(stack_depth), 1);
        chk("pp_status", int'(status), 6'h11);
        chk("pp_err", int'(stack_err), 0);
        pop = 1'b1; wr(1'b1, 6'h3F, 6'h3F); tick();
        chk("pop_wins", int'(status), 6'h10);
        chk("pop_wins_depth", int'(stack_depth), 0);

        // Interrupt-enable behaviour on push
        wr(1'b1, 6'h3F, 6'h20); tick();
        push = 1'b1; tick();
`ifdef STATUS_PUSH_IE_CLR_EN
        chk("ie_push_status", int'(status), 6'h00);
`else
        chk("ie_push_status", int'(status), 6'h20);
`endif
        chk("ie_push_depth", int'(stack_depth), 1);
        pop = 1'b1; tick();
        chk("ie_pop_status", int'(status), 6'h20);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
